ram_readback_checker: RTL and testbench

- Read-side companion to the up-counter ROM-to-RAM fill path in the memory system.
- After the RAM has been populated from ROM, this block walks addresses 0..DEPTH-1 and issues matching synchronous reads to the RAM read port and the ROM.
- Each RAM word is compared against its ROM source word; the block reports mismatch count, first failing address and a pass flag.
- Sits beside the top-level memory system; it owns the RAM read port only while busy.

---
 rtl/rbc_pkg.sv | 7 +
 rtl/rbc_err_accum.sv | 56 +++++
 rtl/ram_readback_checker.sv | 88 ++++++++
 tb/tb_ram_readback_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rbc_pkg.sv
// rbc_pkg: shared state encoding and default sizes for the RAM readback checker
package rbc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int RBC_DEPTH  = 64;
  localparam int RBC_ADDR_W = 8;
  localparam int RBC_DATA_W = 8;
endpackage

// File: rtl/rbc_err_accum.sv
// rbc_err_accum: saturating mismatch counter and first-error capture (optional data capture under RBC_ERR_CAPTURE_EN)
module rbc_err_accum #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic              mismatch,
  input  logic [ADDR_W-1:0] tag,
`ifdef RBC_ERR_CAPTURE_EN
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] got_data,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
`endif
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  logic seen;
  // count mismatches with saturation and latch the tag of the first one in a pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (valid && mismatch) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (!seen) begin
        seen           <= 1'b1;
        first_err_addr <= tag;
      end
    end
  end
`ifdef RBC_ERR_CAPTURE_EN
  // capture the expected and observed words alongside the first failing address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (clr) begin
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (valid && mismatch && !seen) begin
      first_err_exp <= exp_data;
      first_err_got <= got_data;
    end
  end
`endif
endmodule

// File: rtl/ram_readback_checker.sv
// ram_readback_checker: walks RAM and ROM in lockstep and compares each RAM word to its ROM source (RBC_ERR_CAPTURE_EN adds first-error data ports)
module ram_readback_checker
  import rbc_pkg::*;
#(
  parameter int DEPTH  = RBC_DEPTH,
  parameter int ADDR_W = RBC_ADDR_W,
  parameter int DATA_W = RBC_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef RBC_ERR_CAPTURE_EN
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
`endif
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, tag_q;
  logic valid_q, last, mismatch, clr;
  assign last     = addr == ADDR_W'(DEPTH - 1);
  assign mismatch = ram_rd_data != rom_data;
  assign clr      = state == IDLE && start;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // next state: RUN advances only on enabled edges, DRAIN and DONE last one cycle each
  always_comb begin
    state_n = state == IDLE  ? (start ? RUN : IDLE) :
              state == RUN   ? (en && last ? DRAIN : RUN) :
              state == DRAIN ? DONE : IDLE;
  end
  // outputs decoded from state
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  // address walk; valid_q marks the read data of the previous edge as a fresh, compare-worthy word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      pass    <= 1'b0;
    end else begin
      valid_q <= state == RUN && en;
      if (clr) begin
        addr <= '0;
        pass <= 1'b0;
      end
      if (state == RUN && en) begin
        tag_q <= addr;
        if (!last) addr <= addr + 1'b1;
      end
      if (state == DRAIN) pass <= err_count == '0 && !(valid_q && mismatch);
    end
  end
  assign ram_rd_addr = addr;
  assign rom_addr    = addr;
  rbc_err_accum #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_accum (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .valid          (valid_q),
    .mismatch       (mismatch),
    .tag            (tag_q),
`ifdef RBC_ERR_CAPTURE_EN
    .exp_data       (rom_data),
    .got_data       (ram_rd_data),
    .first_err_exp  (first_err_exp),
    .first_err_got  (first_err_got),
`endif
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );
endmodule

// File: tb/tb_ram_readback_checker.sv
// tb_ram_readback_checker: randomized and directed checks of the readback checker against a pass-level model
module tb_ram_readback_checker;
  localparam int DEPTH = 64;
  logic clk = 0, rst = 1, start = 0, en = 0;
  logic [7:0] ram_rd_addr, rom_addr, first_err_addr, err_count, ram_q, rom_q;
  logic [7:0] s_ram_addr, s_rom_addr, s_first, s_ram_q, s_rom_q;
  logic [2:0] s_cnt;
  logic busy, done, pass, s_busy, s_done, s_pass;
`ifdef RBC_ERR_CAPTURE_EN
  logic [7:0] fe_exp, fe_got, s_exp, s_got;
`endif
  logic [7:0] rom [DEPTH], ram [DEPTH];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  ram_readback_checker dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_q),
    .rom_addr(rom_addr), .rom_data(rom_q),
    .busy(busy), .done(done), .pass(pass),
`ifdef RBC_ERR_CAPTURE_EN
    .first_err_exp(fe_exp), .first_err_got(fe_got),
`endif
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  ram_readback_checker #(.CNT_W(3)) sat (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .ram_rd_addr(s_ram_addr), .ram_rd_data(s_ram_q),
    .rom_addr(s_rom_addr), .rom_data(s_rom_q),
    .busy(s_busy), .done(s_done), .pass(s_pass),
`ifdef RBC_ERR_CAPTURE_EN
    .first_err_exp(s_exp), .first_err_got(s_got),
`endif
    .err_count(s_cnt), .first_err_addr(s_first)
  );

  always @(posedge clk) begin
    rom_q   <= rom[rom_addr[5:0]];
    ram_q   <= ram[ram_rd_addr[5:0]];
    s_rom_q <= rom[s_rom_addr[5:0]];
    s_ram_q <= ~rom[s_ram_addr[5:0]];
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // pass-level model: a pass is DEPTH enabled edges, then one drain cycle, then one done cycle
  bit walking = 0, started = 0;
  int issued = 0, tail = 0, m_addr = 0;
  int m_cnt = 0, m_first = 0, m_pass = 0, m_exp = 0, m_got = 0;
  int ms_cnt = 0, ms_first = 0, ms_pass = 0, ms_exp = 0, ms_got = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      walking = 0; started = 0; issued = 0; tail = 0; m_addr = 0;
      m_cnt = 0; m_first = 0; m_pass = 0; m_exp = 0; m_got = 0;
      ms_cnt = 0; ms_first = 0; ms_pass = 0; ms_exp = 0; ms_got = 0;
    end else begin
      bit idle;
      idle = !walking && tail == 0;
      if (tail > 0) tail--;
      if (walking && en) begin
        issued++;
        if (issued == DEPTH) begin walking = 0; tail = 2; end
      end else if (idle && start) begin
        int n, fa, ns, fs;
        n = 0; fa = 0; ns = 0; fs = 0;
        for (int a = 0; a < DEPTH; a++) begin
          if (ram[a] != rom[a]) begin if (n == 0) fa = a; n++; end
          if (~rom[a] != rom[a]) begin if (ns == 0) fs = a; ns++; end
        end
        walking = 1; started = 1; issued = 0;
        m_cnt = n > 255 ? 255 : n; m_first = fa; m_pass = n == 0;
        m_exp = n ? rom[fa] : 0; m_got = n ? ram[fa] : 0;
        ms_cnt = ns > 7 ? 7 : ns; ms_first = fs; ms_pass = ns == 0;
        ms_exp = ns ? rom[fs] : 0; ms_got = ns ? 8'(~rom[fs]) : 0;
      end
      m_addr = walking ? issued : (started ? DEPTH - 1 : 0);
    end
  end

  // compare every cycle; result registers are meaningful whenever the model is not mid-pass
  always @(negedge clk) begin
    if (!rst) begin
      bit mb;
      mb = walking || tail == 2;
      chk("busy", busy, mb);
      chk("done", done, tail == 1);
      chk("ram_rd_addr", ram_rd_addr, m_addr);
      chk("rom_addr", rom_addr, m_addr);
      chk("sat_busy", s_busy, mb);
      chk("sat_done", s_done, tail == 1);
      if (!mb) begin
        chk("err_count", err_count, m_cnt);
        chk("first_err_addr", first_err_addr, m_first);
        chk("pass", pass, m_pass);
        chk("sat_err_count", s_cnt, ms_cnt);
        chk("sat_first_err_addr", s_first, ms_first);
        chk("sat_pass", s_pass, ms_pass);
`ifdef RBC_ERR_CAPTURE_EN
        chk("first_err_exp", fe_exp, m_exp);
        chk("first_err_got", fe_got, m_got);
        chk("sat_first_err_exp", s_exp, ms_exp);
        chk("sat_first_err_got", s_got, ms_got);
`endif
      end
    end
  end

  // drive one pass; lat is the edge count from the start edge to the edge after which done is high
  task automatic run_pass(input int stall_at, input int stall_len, input int restart_at,
                          input bit rnd_en, output int lat, output int busy_cyc);
    int j, stalled, cur;
    start = 1; en = 1;
    @(negedge clk);
    start = 0; j = 0; stalled = 0; lat = -1; busy_cyc = 0;
    while (j < 400 && lat < 0) begin
      cur = j - stalled;
      start = cur == restart_at;
      if (rnd_en) en = $urandom_range(0, 3) != 0;
      else if (cur == stall_at && stalled < stall_len) begin en = 0; stalled++; end
      else en = 1;
      if (busy) busy_cyc++;
      if (done) lat = j;
      @(negedge clk);
      j++;
    end
    start = 0; en = 1;
    if (lat < 0) chk("done_timeout", 0, 1);
    #2;
  endtask

  task automatic clean_image();
    for (int a = 0; a < DEPTH; a++) begin rom[a] = 8'($urandom); ram[a] = rom[a]; end
  endtask

  initial begin
    int lat, bc;
    clean_image();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0); chk("rst_addr", ram_rd_addr, 0);
    rst = 0;
    @(negedge clk);
    // clean pass
    run_pass(-1, 0, -1, 0, lat, bc);
    chk("clean_latency", lat, 65); chk("clean_busy_cycles", bc, 65);
    chk("clean_err_count", err_count, 0); chk("clean_pass", pass, 1);
    chk("sat_err_count_lit", s_cnt, 7); chk("sat_first_lit", s_first, 0); chk("sat_pass_lit", s_pass, 0);
    chk("idle_addr_lit", ram_rd_addr, 63);
    // two corrupt words
    clean_image(); ram[5] ^= 8'h01; ram[40] ^= 8'h01;
    run_pass(-1, 0, -1, 0, lat, bc);
    chk("two_err_count", err_count, 2); chk("two_first", first_err_addr, 5); chk("two_pass", pass, 0);
`ifdef RBC_ERR_CAPTURE_EN
    chk("two_exp", fe_exp, rom[5]); chk("two_got", fe_got, rom[5] ^ 8'h01);
`endif
    // stall at address 20 on a clean image, then with 20 corrupted
    clean_image();
    run_pass(20, 10, -1, 0, lat, bc);
    chk("stall_latency", lat, 75); chk("stall_busy_cycles", bc, 75); chk("stall_err_count", err_count, 0);
    ram[20] ^= 8'h80;
    run_pass(20, 10, -1, 0, lat, bc);
    chk("stall20_err_count", err_count, 1); chk("stall20_first", first_err_addr, 20);
    // start while busy is ignored
    clean_image(); ram[7] ^= 8'h10;
    run_pass(-1, 0, 30, 0, lat, bc);
    chk("restart_latency", lat, 65); chk("restart_err_count", err_count, 1);
    // asynchronous reset mid-pass
    start = 1; en = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("pre_reset_addr", ram_rd_addr, 12);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_addr", ram_rd_addr, 0); chk("arst_rom_addr", rom_addr, 0);
    chk("arst_err_count", err_count, 0); chk("arst_pass", pass, 0); chk("arst_first", first_err_addr, 0);
    @(negedge clk);
    rst = 0;
    begin
      int pulses = 0;
      repeat (80) begin @(negedge clk); if (done) pulses++; end
      chk("arst_no_done", pulses, 0);
    end
    clean_image();
    run_pass(-1, 0, -1, 0, lat, bc);
    chk("post_reset_latency", lat, 65); chk("post_reset_pass", pass, 1);
    // randomized images with random enable
    repeat (4) begin
      clean_image();
      repeat ($urandom_range(0, 5)) ram[$urandom_range(0, DEPTH - 1)] ^= 8'($urandom_range(1, 255));
      run_pass(-1, 0, $urandom_range(0, 63), 1, lat, bc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
